uart_echo_buffer: RTL and testbench
===================================

# uart_echo_buffer

Parametrised AXI-Stream echo engine placed between the UART receiver output (m_axis) and the UART transmitter input (s_axis) in the serial-terminal top level. It replaces single-byte echo with a DEPTH-entry FIFO plus a registered output stage. Per-byte transforms: uppercase folding, CR→CR LF expansion and mute. It reports a drop counter and fill level for LEDs/debug.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width; transforms active only when 8
- DEPTH, 16, FIFO entries, power of two, ≥2
- CRLF_EXPAND, 1, 1 = insert LF (0x0A) after every CR (0x0D) sent
- DROP_ON_FULL, 1, 1 = s_axis_tready held high, bytes arriving while full are discarded and counted; 0 = tready = !full

Ports:
- clk_125mhz  in  1  clock
- rst_125mhz  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  DATA_WIDTH  byte from UART RX
- s_axis_tvalid  in  1  RX byte valid
- s_axis_tready  out  1  accept
- m_axis_tdata  out  DATA_WIDTH  byte to UART TX
- m_axis_tvalid  out  1  TX byte valid
- m_axis_tready  in  1  TX accept
- mode  in  2  0 echo, 1 uppercase, 2 mute, 3 = echo
- flush  in  1  synchronous FIFO clear
- level  out  $clog2(DEPTH+1)  FIFO occupancy, output register excluded
- drop_count  out  16  dropped bytes, saturating at 0xFFFF

## Operation
- Reset: FIFO empty, level=0, m_axis_tvalid=0, m_axis_tdata=0, drop_count=0, output FSM in SEND.
- Reset output value of s_axis_tready: 1 if DROP_ON_FULL, else 1 (FIFO empty).
- Write: on s_axis_tvalid&&s_axis_tready, mode sampled that cycle.
  - mode 2: byte discarded, not counted.
  - mode 1 and DATA_WIDTH==8: 0x61–0x7A minus 0x20, else unchanged.
  - Write into FIFO if not full.
  - If full (DROP_ON_FULL=1): byte discarded and drop_count++ (saturating), even if a pop occurs the same cycle.
- Read: output register loads from FIFO head when (m_axis_tvalid==0 or m_axis_tready==1) and FIFO non-empty and FSM in SEND.
- Output FSM, two states:
  - SEND: normal. When a CR is accepted (m_axis_tvalid&&m_axis_tready&&tdata==0x0D) and CRLF_EXPAND=1 → LF.
  - LF: output register holds 0x0A with tvalid=1, no pop. On acceptance → SEND.
- AXI rule: once m_axis_tvalid=1, tdata/tvalid stay stable until handshake; flush and mode never alter the output register.
- flush: pointers and level cleared next edge. A write in the same cycle is discarded (not counted). Output register and LF pending still drain.
- Simultaneous write+pop: level unchanged, both take effect.
- Pointers wrap modulo DEPTH; full = level==DEPTH.

## Timing
- Latency: byte accepted at edge N with FIFO and output register empty → m_axis_tvalid=1 after edge N+1 (one-cycle FIFO, one register stage).
- Throughput: one byte per cycle both sides when TX ready; LF insertion costs one output slot.
- level and drop_count registered, update on the edge following the event.
- DROP_ON_FULL=0: s_axis_tready = (level!=DEPTH), combinational from registered level.
- Reset mid-transfer: everything cleared asynchronously, in-flight byte lost, no partial LF.

## Structure
- Package uart_echo_pkg: ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_a/z, CASE_OFFSET=8'h20, mode encodings MODE_ECHO/MODE_UPPER/MODE_MUTE, FSM state enum.
- One sub-module: sync_fifo (DATA_WIDTH, DEPTH; wr_en/rd_en/flush, dout, level, full, empty, registered pointers). Transform, drop logic and output FSM in the top.

## Test plan
- Echo: mode 0, send 0x41,0x62 with m_axis_tready=1 → output 0x41,0x62, first tvalid one edge after accept.
- Uppercase: mode 1, send "az{" (0x61,0x7A,0x7B) → 0x41,0x5A,0x7B.
- CRLF: send 0x0D,0x31 → 0x0D,0x0A,0x31; with tready stalled 5 cycles after CR, 0x0A held stable.
- Overflow: DEPTH=16, tready=0, send 20 bytes → level=16, drop_count=3 (17th sits in output register), release → 17 bytes out in order.
- Flush/mute: 5 bytes queued with tready=0, pulse flush → level=0, only output-register byte emitted; mode 2 input → no output, drop_count unchanged.
- Async reset asserted mid-stream → all outputs at reset values before next clock edge.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// Shared constants, mode encodings and output FSM states for the UART echo buffer.
package uart_echo_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_a     = 8'h61;
  localparam logic [7:0] ASCII_z     = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam logic [1:0] MODE_ECHO  = 2'd0;
  localparam logic [1:0] MODE_UPPER = 2'd1;
  localparam logic [1:0] MODE_MUTE  = 2'd2;

  typedef enum logic {
    ST_SEND,
    ST_LF
  } out_state_e;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= ASCII_a && b <= ASCII_z) return b - CASE_OFFSET;
    return b;
  endfunction

endpackage

// File: rtl/uart_echo_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and synchronous flush.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_125mhz,
  input  logic                  rst_125mhz,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  always_ff @(posedge clk_125mhz) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_125mhz or posedge rst_125mhz) begin
    if (rst_125mhz) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// AXI-Stream echo engine: per-byte transform, FIFO, registered output with CR->CRLF expansion.
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int CRLF_EXPAND  = 1,
  parameter int DROP_ON_FULL = 1
) (
  input  logic                         clk_125mhz,
  input  logic                         rst_125mhz,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic [1:0]                   mode,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [15:0]                  drop_count
);

  localparam bit IS_BYTE  = (DATA_WIDTH == 8);
  localparam bit DO_CRLF  = IS_BYTE && (CRLF_EXPAND != 0);

  out_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  valid_nxt;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic                  rx_take;
  logic                  drop_evt;
  logic                  tx_hs;

  assign s_axis_tready = (DROP_ON_FULL != 0) ? 1'b1 : !fifo_full;

  // Muted bytes and bytes arriving during flush vanish without touching the drop count.
  assign rx_take  = s_axis_tvalid && s_axis_tready && (mode != MODE_MUTE) && !flush;
  assign fifo_wr  = rx_take && !fifo_full;
  assign drop_evt = rx_take && fifo_full;
  assign tx_hs    = m_axis_tvalid && m_axis_tready;

  always_comb begin
    wr_data = s_axis_tdata;
    case (mode)
      MODE_UPPER: if (IS_BYTE) wr_data = DATA_WIDTH'(to_upper(8'(s_axis_tdata)));
      MODE_ECHO:  wr_data = s_axis_tdata;
      default:    wr_data = s_axis_tdata;
    endcase
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_125mhz (clk_125mhz),
    .rst_125mhz (rst_125mhz),
    .wr_en      (fifo_wr),
    .din        (wr_data),
    .rd_en      (fifo_rd),
    .flush      (flush),
    .dout       (fifo_dout),
    .level      (level),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    data_nxt  = m_axis_tdata;
    valid_nxt = m_axis_tvalid;
    fifo_rd   = 1'b0;
    case (state)
      ST_SEND: begin
        // An accepted CR takes the next output slot for LF instead of a FIFO pop.
        if (DO_CRLF && tx_hs && (m_axis_tdata == DATA_WIDTH'(ASCII_CR))) begin
          state_nxt = ST_LF;
          data_nxt  = DATA_WIDTH'(ASCII_LF);
          valid_nxt = 1'b1;
        end else if ((!m_axis_tvalid || m_axis_tready) && !fifo_empty && !flush) begin
          fifo_rd   = 1'b1;
          data_nxt  = fifo_dout;
          valid_nxt = 1'b1;
        end else if (tx_hs) begin
          valid_nxt = 1'b0;
        end
      end
      ST_LF: begin
        if (tx_hs) begin
          state_nxt = ST_SEND;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_SEND;
    endcase
  end

  always_ff @(posedge clk_125mhz or posedge rst_125mhz) begin
    if (rst_125mhz) begin
      state         <= ST_SEND;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      drop_count    <= '0;
    end else begin
      state         <= state_nxt;
      m_axis_tdata  <= data_nxt;
      m_axis_tvalid <= valid_nxt;
      if (drop_evt && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer against a queue-level reference model.
module tb_uart_echo_buffer;

  localparam int DEPTH = 16;

  logic       clk_125mhz = 1'b0;
  logic       rst_125mhz;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [1:0] mode;
  logic       flush;
  logic [4:0] level;
  logic [15:0] drop_count;

  always #5 clk_125mhz = ~clk_125mhz;

  uart_echo_buffer #(
    .DATA_WIDTH   (8),
    .DEPTH        (DEPTH),
    .CRLF_EXPAND  (1),
    .DROP_ON_FULL (1)
  ) dut (
    .clk_125mhz    (clk_125mhz),
    .rst_125mhz    (rst_125mhz),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .mode          (mode),
    .flush         (flush),
    .level         (level),
    .drop_count    (drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  // Model: bytes waiting in the FIFO, words held by the output stage
  // (bit 8 marks an inserted LF), and the expected output stream.
  logic [7:0] mfifo[$];
  logic [8:0] sq[$];
  logic [7:0] exp_q[$];
  int         mdrop = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mfifo.delete();
    sq.delete();
    exp_q.delete();
    mdrop = 0;
  endtask

  task automatic model_step(input bit tv, input logic [7:0] td, input logic [1:0] md,
                            input bit fl, input bit tr);
    logic [8:0] head;
    logic [7:0] b;
    bit         can_load;
    int         sz;
    sz       = mfifo.size();
    can_load = (sq.size() == 0);
    if (sq.size() != 0 && tr) begin
      head     = sq.pop_front();
      can_load = (sq.size() == 0) && !head[8];
    end
    if (can_load && sz != 0 && !fl) begin
      b = mfifo.pop_front();
      sq.push_back({1'b0, b});
      exp_q.push_back(b);
      if (b == 8'h0D) begin
        sq.push_back({1'b1, 8'h0A});
        exp_q.push_back(8'h0A);
      end
    end
    if (fl) mfifo.delete();
    else if (tv && md != 2'd2) begin
      b = td;
      if (md == 2'd1 && b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
      if (sz == DEPTH) begin
        if (mdrop < 16'hFFFF) mdrop++;
      end else begin
        mfifo.push_back(b);
      end
    end
  endtask

  task automatic cycle(input bit tv, input logic [7:0] td, input logic [1:0] md,
                       input bit fl, input bit tr);
    @(posedge clk_125mhz);
    #2;
    chk("tvalid", int'(m_axis_tvalid), int'(sq.size() != 0));
    if (sq.size() != 0) chk("tdata_held", int'(m_axis_tdata), int'(sq[0][7:0]));
    chk("level", int'(level), mfifo.size());
    chk("drop_count", int'(drop_count), mdrop);
    chk("s_tready", int'(s_axis_tready), 1);
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    mode          = md;
    flush         = fl;
    m_axis_tready = tr;
    model_step(tv, td, md, fl, tr);
  endtask

  task automatic idle(input int n, input bit tr);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 2'd0, 1'b0, tr);
  endtask

  task automatic check_reset_values();
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_s_tready", int'(s_axis_tready), 1);
  endtask

  // Monitor: every output handshake consumes the next expected byte.
  initial begin
    forever begin
      @(negedge clk_125mhz);
      if (!rst_125mhz && m_axis_tvalid && m_axis_tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_unexpected: got 0x%0h expected nothing at %0t", m_axis_tdata, $time);
        end else begin
          chk("out_byte", int'(m_axis_tdata), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int base;
    int trp;
    logic [7:0] td;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    mode          = 2'd0;
    flush         = 1'b0;
    rst_125mhz    = 1'b1;
    model_clear();
    repeat (3) @(posedge clk_125mhz);
    #2;
    check_reset_values();
    rst_125mhz = 1'b0;

    // Echo
    cycle(1'b1, 8'h41, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'h62, 2'd0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Uppercase
    cycle(1'b1, 8'h61, 2'd1, 1'b0, 1'b1);
    cycle(1'b1, 8'h7A, 2'd1, 1'b0, 1'b1);
    cycle(1'b1, 8'h7B, 2'd1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // CR LF expansion, then LF held under stall
    cycle(1'b1, 8'h0D, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'h31, 2'd0, 1'b0, 1'b1);
    idle(5, 1'b1);
    cycle(1'b1, 8'h0D, 2'd3, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(5, 1'b0);
    idle(4, 1'b1);

    // Overflow
    base = n_out;
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h80 + 8'(i), 2'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("ovf_level", int'(level), 16);
    chk("ovf_drop", int'(drop_count), 3);
    idle(25, 1'b1);
    chk("ovf_out_count", n_out - base, 17);

    // Flush
    base = n_out;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h50 + 8'(i), 2'd0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("flush_level", int'(level), 0);
    idle(5, 1'b1);
    chk("flush_out_count", n_out - base, 1);

    // Mute
    base = n_out;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h30 + 8'(i), 2'd2, 1'b0, 1'b1);
    idle(4, 1'b1);
    chk("mute_out_count", n_out - base, 0);
    chk("mute_drop", int'(drop_count), 3);

    // Randomised traffic
    trp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       trp = 10;
          1:       trp = 50;
          default: trp = 95;
        endcase
      end
      case ($urandom_range(0, 9))
        0:       td = 8'h0D;
        1, 2, 3: td = 8'h61 + 8'($urandom_range(0, 25));
        default: td = 8'($urandom);
      endcase
      cycle($urandom_range(0, 9) < 7, td, 2'($urandom_range(0, 3)),
            $urandom_range(0, 63) == 0, $urandom_range(0, 99) < trp);
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'h0D, 2'd0, 1'b0, 1'b0);
    @(posedge clk_125mhz);
    #2;
    rst_125mhz    = 1'b1;
    s_axis_tvalid = 1'b0;
    flush         = 1'b0;
    #1;
    check_reset_values();
    model_clear();
    #1;
    rst_125mhz = 1'b0;
    cycle(1'b1, 8'h0D, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 8'h77, 2'd1, 1'b0, 1'b1);
    idle(40, 1'b1);
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
